cmd_queue_sched: RTL
====================

// Module: cmd_queue_sched
// PURPOSE
//  Write-side scheduler for the 16-entry command queue between FETCH and DECODE.
//  Shares the queue's single write port between the fetch unit and the debug/inject port.
//  Tracks queue occupancy as credits, back-pressures producers when full, and sequences flushes.
//  The queue entry format is {14b data, 12b addr, 4b opcode}; this block never interprets it.
// PARAMETERS
//  DATA_W      30  command entry width
//  DEPTH       16  queue entries; credits available after reset/flush
//  CNT_W       5   occupancy counter width; must hold 0..DEPTH
//  SETTLE_CYC  2   idle cycles after a flush before writes resume (>=1)
// PORTS
//  clk           in   1       system clock; all logic on posedge
//  reset         in   1       synchronous, active-high
//  fetch_valid   in   1       fetch offers fetch_data
//  fetch_data    in   DATA_W  fetch command entry
//  fetch_ready   out  1       fetch transfer accepted this cycle when valid&ready
//  dbg_valid     in   1       debug port offers dbg_data
//  dbg_data      in   DATA_W  debug command entry
//  dbg_ready     out  1       debug transfer accepted this cycle when valid&ready
//  dbg_prio      in   1       1: debug has strict priority over fetch
//  q_rd_done     in   1       DECODE popped one entry this cycle
//  flush         in   1       discard queue contents (branch/redirect)
//  q_wr_en       out  1       registered write strobe to queue
//  q_wr_data     out  DATA_W  registered write data to queue
//  q_clear       out  1       one-cycle pulse: queue invalidates all entries
//  occupancy     out  CNT_W   entries written and not yet popped
//  full          out  1       occupancy == DEPTH
//  err_underflow out  1       sticky: q_rd_done seen with occupancy 0
// BEHAVIOUR
//  Reset: state=RUN, q_wr_en=0, q_wr_data=0, q_clear=0, occupancy=0, err_underflow=0,
//   last_grant=DBG (so fetch wins the first contention); readies 0 while reset=1.
//  FSM: RUN, FULL, FLUSH, SETTLE.
//   RUN:    readies per arbitration; -> FULL when next occupancy == DEPTH.
//   FULL:   readies=0; -> RUN on q_rd_done (occupancy drops to DEPTH-1).
//   FLUSH:  single cycle; q_clear=1, occupancy<=0, readies=0; -> SETTLE, counter=SETTLE_CYC-1.
//   SETTLE: readies=0; counts down; -> RUN when counter==0.
//   flush=1 in ANY state -> FLUSH next cycle (re-entry restarts settle count).
//  Flush priority: flush=1 forces both readies to 0 combinationally the same cycle;
//   no transfer completes on a flush cycle; q_rd_done on a flush cycle is ignored.
//  Arbitration (RUN only, occupancy < DEPTH):
//   one valid -> that requester granted; both valid & dbg_prio=1 -> debug;
//   both valid & dbg_prio=0 -> requester != last_grant (round robin).
//   last_grant updates only on a completed transfer. At most one ready high per cycle.
//  Ready is combinational from state, occupancy, valids, dbg_prio, flush, last_grant.
//  Latency: transfer at edge N -> q_wr_en=1, q_wr_data=entry during cycle N+1; q_wr_en=0 otherwise
//   (q_wr_data holds last value).
//  Occupancy: +1 on transfer, -1 on q_rd_done (if occupancy>0), both -> unchanged.
//   q_rd_done at occupancy 0: counter stays 0, err_underflow<=1 (cleared only by reset).
//  Boundary: RUN at DEPTH-1 with transfer and pop same cycle -> stays RUN, occupancy DEPTH-1.
//   Reset mid-transfer or mid-flush: reset wins; pending q_wr_en dropped.
// TESTING
//  1 Fetch-only stream of 16 entries, no pops -> 16 q_wr_en pulses 1 cycle after each
//    accept, occupancy 16, full=1, state FULL, fetch_ready=0; one q_rd_done -> occupancy 15, ready=1.
//  2 Both valid, dbg_prio=0, 6 cycles -> grants fetch,dbg,fetch,dbg,fetch,dbg; q_wr_data matches order.
//  3 Both valid, dbg_prio=1 -> debug granted every cycle, fetch_ready=0 throughout.
//  4 occupancy 9, flush with fetch_valid=1 -> no transfer that cycle, next cycle q_clear=1,
//    occupancy 0, readies 0 for SETTLE_CYC=2 cycles, then fetch accepted.
//  5 occupancy 15, transfer+q_rd_done same cycle -> occupancy 15, full=0; q_rd_done at 0 ->
//    err_underflow=1, occupancy 0.
//  6 reset asserted in SETTLE and one cycle after a transfer -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/cmd_queue_sched_if.sv
// Producer/consumer signal bundle for the command-queue write scheduler.
// The master side drives requests and queue feedback; the slave side is the scheduler.
interface cmd_queue_sched_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 5
) ();
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_ready;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;
    logic              dbg_prio;
    logic              q_rd_done;
    logic              flush;
    logic              q_wr_en;
    logic [DATA_W-1:0] q_wr_data;
    logic              q_clear;
    logic [CNT_W-1:0]  occupancy;
    logic              full;
    logic              err_underflow;

    modport master (
        output fetch_valid, fetch_data, dbg_valid, dbg_data, dbg_prio, q_rd_done, flush,
        input  fetch_ready, dbg_ready, q_wr_en, q_wr_data, q_clear, occupancy, full,
               err_underflow
    );

    modport slave (
        input  fetch_valid, fetch_data, dbg_valid, dbg_data, dbg_prio, q_rd_done, flush,
        output fetch_ready, dbg_ready, q_wr_en, q_wr_data, q_clear, occupancy, full,
               err_underflow
    );
endinterface

// File: rtl/cmd_queue_sched.sv
// Write-side scheduler for the FETCH->DECODE command queue: arbitrates fetch vs debug
// onto the single write port, tracks occupancy as credits and sequences flushes.
module cmd_queue_sched #(
    parameter int DATA_W     = 30,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 5,
    parameter int SETTLE_CYC = 2
) (
    input logic               clk,
    input logic               reset,
    cmd_queue_sched_if.slave  bus
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {RUN, FULL, FLUSH, SETTLE} state_t;

    state_t            state, state_next;
    logic              last_dbg;
    logic [SET_W-1:0]  settle_cnt;
    logic              grant_fetch, grant_dbg, xfer, pop, dec, underflow;
    logic [CNT_W-1:0]  occ, occ_next;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              err;

    // Flush and reset mask the readies in the same cycle, so no transfer can slip through.
    always_comb begin
        grant_fetch = 1'b0;
        grant_dbg   = 1'b0;
        if (!reset && !bus.flush && state == RUN && occ < DEPTH_C) begin
            if (bus.fetch_valid && bus.dbg_valid) begin
                if (bus.dbg_prio || !last_dbg) grant_dbg   = 1'b1;
                else                           grant_fetch = 1'b1;
            end else begin
                grant_fetch = bus.fetch_valid;
                grant_dbg   = bus.dbg_valid;
            end
        end
    end

    assign xfer      = grant_fetch | grant_dbg;
    assign pop       = bus.q_rd_done & ~bus.flush;
    assign dec       = pop && (occ != '0);
    assign underflow = pop && (occ == '0);
    assign occ_next  = occ + CNT_W'(xfer) - CNT_W'(dec);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (occ_next == DEPTH_C) state_next = FULL;
            FULL:    if (pop) state_next = RUN;
            FLUSH:   state_next = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
        if (bus.flush) state_next = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            last_dbg   <= 1'b1;
            settle_cnt <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            occ        <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            wr_en <= xfer;
            if (xfer) begin
                wr_data  <= grant_dbg ? bus.dbg_data : bus.fetch_data;
                last_dbg <= grant_dbg;
            end
            occ <= bus.flush ? '0 : occ_next;
            if (underflow) err <= 1'b1;
            // Reloading in FLUSH means a flush during SETTLE restarts the full settle window.
            if (state == FLUSH)
                settle_cnt <= SETTLE_C;
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
        end
    end

    assign bus.fetch_ready   = grant_fetch;
    assign bus.dbg_ready     = grant_dbg;
    assign bus.q_wr_en       = wr_en;
    assign bus.q_wr_data     = wr_data;
    assign bus.q_clear       = (state == FLUSH);
    assign bus.occupancy     = occ;
    assign bus.full          = (occ == DEPTH_C);
    assign bus.err_underflow = err;
endmodule
